musa_trace_buffer: RTL and testbench

Synthesizable execution-trace recorder for the MUSA core. It samples the per-instruction control and writeback signals the simulation monitor currently probes hierarchically (pc_src, mem_read/mem_write, push/pop, alu_op, reg_write, instruction, writeback data) into a circular buffer. Each record carries a cycle timestamp. Three capture modes are supported: free-running wrap, stop-when-full and trigger with post-trigger window. After capture, records are read out oldest-first through a one-cycle-latency port. The block sits beside dataPath and observes it passively; it never drives the core.

---
 rtl/musa_trace_buffer.sv | 157 +++++++++++++++
 tb/tb_musa_trace_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/musa_trace_buffer.sv
// musa_trace_buffer
// Passive execution-trace recorder for the MUSA core. Each retiring
// instruction (cap_valid) is stored with a cycle timestamp in a circular
// buffer. Capture modes: 0 = free-running wrap, 1 = stop-when-full,
// 2 = trigger plus post-trigger window (3 behaves as 0). After capture the
// records are read oldest-first through a one-cycle-latency port.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   cap_valid           record this cycle's retiring instruction
//   pc_src .. reg_write control flags of the retiring instruction
//   alu_op, instruction, wb_data  recorded payload
//   mode                capture mode, latched on arm
//   arm / disarm        start (clears buffer) / stop capture
//   trig                trigger event for mode 2
//   rd_en               read request (honoured in DONE only)
//   rd_data, rd_valid   record {ts, flags, alu_op, instruction, wb_data}
//   count               records currently held
//   state               0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   overflow            a record was overwritten since arm
module musa_trace_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int INSTR_WIDTH  = 32,
  parameter int ALU_OP_WIDTH = 6,
  parameter int TS_WIDTH     = 16,
  parameter int DEPTH        = 16,
  parameter int POST_COUNT   = 4,
  localparam int ENTRY_W = TS_WIDTH + 6 + ALU_OP_WIDTH + INSTR_WIDTH + DATA_WIDTH,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int CNT_W   = ADDR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_valid,
  input  logic                    pc_src,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    reg_write,
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [INSTR_WIDTH-1:0]  instruction,
  input  logic [DATA_WIDTH-1:0]   wb_data,
  input  logic [1:0]              mode,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    trig,
  input  logic                    rd_en,
  output logic [ENTRY_W-1:0]      rd_data,
  output logic                    rd_valid,
  output logic [CNT_W-1:0]        count,
  output logic [1:0]              state,
  output logic                    overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  rec_p0;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]   post_left;
  logic [TS_WIDTH-1:0] ts;
  logic [1:0]          mode_q;
  logic                capturing;
  logic                cap_en;
  logic                rd_fire;
  logic                full;

  // Stage p0: record assembled from the live core signals and current ts
  assign rec_p0 = {ts, pc_src, mem_read, mem_write, push, pop, reg_write,
                   alu_op, instruction, wb_data};

  // arm wins over everything else in its cycle, so it masks capture and read
  assign capturing = (state == S_ARMED) || (state == S_POST);
  assign cap_en    = !arm && capturing && cap_valid;
  assign rd_fire   = !arm && (state == S_DONE) && rd_en && (count != '0);
  assign full      = (count == CNT_FULL);

  // Record storage holds data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (cap_en) begin
      mem[wr_ptr] <= rec_p0;
    end
  end

  // Stage p1: control state and registered read port
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ts        <= '0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      mode_q    <= 2'd0;
      post_left <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (arm) begin
        state     <= S_ARMED;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        ts        <= '0;
        overflow  <= 1'b0;
        post_left <= '0;
        mode_q    <= (mode == 2'd3) ? 2'd0 : mode;
      end else begin
        if (capturing) begin
          ts <= ts + TS_WIDTH'(1);
          if (cap_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (full) begin
              // Wrap: drop the oldest record by dragging the read side along
              rd_ptr   <= rd_ptr + ADDR_W'(1);
              overflow <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          if (disarm) begin
            state <= S_DONE;
          end else if ((mode_q == 2'd1) && cap_en && (count == CNT_LAST)) begin
            state <= S_DONE;
          end else if (mode_q == 2'd2) begin
            if ((state == S_ARMED) && trig) begin
              // A capture in the trigger cycle is not part of the window
              post_left <= ADDR_W'(POST_COUNT);
              state     <= (POST_COUNT == 0) ? S_DONE : S_POST;
            end else if ((state == S_POST) && cap_en) begin
              post_left <= post_left - ADDR_W'(1);
              if (post_left == ADDR_W'(1)) begin
                state <= S_DONE;
              end
            end
          end
        end
        if (rd_fire) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + ADDR_W'(1);
          count    <= count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_musa_trace_buffer.sv
module tb_musa_trace_buffer;

  localparam int DW = 32;
  localparam int IW = 32;
  localparam int AW = 6;
  localparam int TW = 16;
  localparam int EW = TW + 6 + AW + IW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cap_valid = 1'b0;
  logic          pc_src = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic          push = 1'b0, pop = 1'b0, reg_write = 1'b0;
  logic [AW-1:0] alu_op = '0;
  logic [IW-1:0] instruction = '0;
  logic [DW-1:0] wb_data = '0;
  logic [1:0]    mode = 2'd0;
  logic          arm = 1'b0, disarm = 1'b0, trig = 1'b0, rd_en = 1'b0;

  logic [EW-1:0] rd_data, rd_data0;
  logic          rd_valid, rd_valid0;
  logic [4:0]    count, count0;
  logic [1:0]    state, state0;
  logic          overflow, overflow0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] sb[$];
  logic [EW-1:0] last_rec;

  always #5 clk = ~clk;

  musa_trace_buffer #(.DEPTH(16), .POST_COUNT(4)) u_dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
    .reg_write(reg_write), .alu_op(alu_op), .instruction(instruction),
    .wb_data(wb_data), .mode(mode), .arm(arm), .disarm(disarm), .trig(trig),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .state(state), .overflow(overflow));

  musa_trace_buffer #(.DEPTH(16), .POST_COUNT(0)) u_dut0 (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
    .reg_write(reg_write), .alu_op(alu_op), .instruction(instruction),
    .wb_data(wb_data), .mode(mode), .arm(arm), .disarm(disarm), .trig(trig),
    .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0),
    .state(state0), .overflow(overflow0));

  function automatic logic [EW-1:0] mk(input int k, input int t);
    logic [5:0]    f;
    logic [AW-1:0] a;
    logic [IW-1:0] ins;
    logic [DW-1:0] wb;
    f   = 6'(k * 7);
    a   = AW'(k + 3);
    ins = IW'(k);
    wb  = 32'hC0DE0000 + DW'(k * k);
    return {TW'(t), f, a, ins, wb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_arm(input logic [1:0] m);
    sb.delete();
    mode = m;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
  endtask

  // Drives capture k; a record expected in the buffer is queued with ts = k
  task automatic cap(input int k, input bit keep, input bit t);
    logic [EW-1:0] r;
    r = mk(k, k);
    {pc_src, mem_read, mem_write, push, pop, reg_write} = r[EW-TW-1 -: 6];
    alu_op      = r[IW+DW +: AW];
    instruction = r[DW +: IW];
    wb_data     = r[DW-1:0];
    cap_valid   = 1'b1;
    trig        = t;
    if (keep) sb.push_back(r);
    tick();
    cap_valid = 1'b0;
    trig      = 1'b0;
  endtask

  task automatic rd_stream(input int n, input string tag);
    logic [EW-1:0] e;
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      chk({tag, "_vld"}, 128'(rd_valid), 128'(1));
      chk({tag, "_data"}, 128'(rd_data), 128'(e));
      last_rec = e;
    end
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset held with arm asserted
    arm = 1'b1;
    tick();
    tick();
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("rst_rdv", 128'(rd_valid), 128'(0));
    chk("rst_rdd", 128'(rd_data), 128'(0));
    arm = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_state", 128'(state), 128'(0));

    // Mode 1: stop when full
    do_arm(2'd1);
    chk("m1_armed", 128'(state), 128'(1));
    chk("m1_cnt0", 128'(count), 128'(0));
    for (int k = 0; k < 20; k++) begin
      cap(k, k < 16, 1'b0);
      if (k == 14) chk("m1_not_done", 128'(state), 128'(1));
      if (k == 15) chk("m1_done16", 128'(state), 128'(3));
    end
    chk("m1_count", 128'(count), 128'(16));
    chk("m1_ovf", 128'(overflow), 128'(0));
    rd_stream(16, "m1_rd");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("m1_rd17_vld", 128'(rd_valid), 128'(0));
    chk("m1_rd17_hold", 128'(rd_data), 128'(last_rec));
    chk("m1_empty", 128'(count), 128'(0));

    // Mode 0: wrap, then disarm
    do_arm(2'd0);
    for (int k = 0; k < 20; k++) cap(k, 1'b1, 1'b0);
    while (sb.size() > 16) void'(sb.pop_front());
    chk("m0_state_armed", 128'(state), 128'(1));
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    chk("m0_state", 128'(state), 128'(3));
    chk("m0_count", 128'(count), 128'(16));
    chk("m0_ovf", 128'(overflow), 128'(1));
    rd_stream(16, "m0_rd");
    chk("m0_first_last", 128'(last_rec[DW +: IW]), 128'(19));

    // Mode 2, POST_COUNT = 4
    do_arm(2'd2);
    for (int k = 0; k < 16; k++) begin
      cap(k, k <= 13, k == 9);
      if (k == 9)  chk("m2_post", 128'(state), 128'(2));
      if (k == 12) chk("m2_still_post", 128'(state), 128'(2));
      if (k == 13) chk("m2_done", 128'(state), 128'(3));
    end
    chk("m2_count", 128'(count), 128'(14));
    chk("m2_ovf", 128'(overflow), 128'(0));
    rd_stream(14, "m2_rd");
    chk("m2_last_instr", 128'(last_rec[DW +: IW]), 128'(13));

    // Mode 2, POST_COUNT = 0 (second instance)
    do_arm(2'd2);
    for (int k = 0; k < 3; k++) cap(k, 1'b0, 1'b0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("p0_done", 128'(state0), 128'(3));
    chk("p0_count", 128'(count0), 128'(3));
    chk("p4_post", 128'(state), 128'(2));
    cap(3, 1'b0, 1'b0);
    chk("p0_count_hold", 128'(count0), 128'(3));
    chk("p4_count", 128'(count), 128'(4));

    // Priority: arm + disarm + rd_en in DONE
    do_arm(2'd1);
    for (int k = 0; k < 5; k++) cap(k, 1'b0, 1'b0);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    chk("pr_done", 128'(state), 128'(3));
    chk("pr_count5", 128'(count), 128'(5));
    arm = 1'b1;
    disarm = 1'b1;
    rd_en = 1'b1;
    tick();
    arm = 1'b0;
    disarm = 1'b0;
    chk("pr_state", 128'(state), 128'(1));
    chk("pr_count", 128'(count), 128'(0));
    chk("pr_rdv", 128'(rd_valid), 128'(0));
    tick();
    rd_en = 1'b0;
    chk("pr_armed_rdv", 128'(rd_valid), 128'(0));
    chk("pr_armed_state", 128'(state), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
